frame_swap_ctrl: RTL and testbench
==================================

Name: frame_swap_ctrl

Overview:
Double-buffer scheduler between the camera capture path and the 640x480 VGA scan-out, sharing one 2-bank frame buffer (2 x 2^19 x 12 bit).
- Camera writes go to the back bank. VGA reads come from the front bank.
- The banks swap only at the start of VGA vsync, once the back bank holds a complete frame. This gives tear-free display.
- The block sits between the capture block, the frame buffer BRAM and the VGA timing block, in the clk25 domain.

Parameters:
ADDR_W, 19, per-bank pixel address width
DATA_W, 12, pixel width (RGB444)
FRAME_PIXELS, 307200, writes required for a complete frame (640*480)
CNT_W, 8, width of the statistics counters
VSYNC_ACTIVE, 0, active level of vga_vsync

Ports:
clk25  in  1  pixel clock. All logic is on its rising edge.
resetn  in  1  synchronous, active-low reset
cam_sof  in  1  1-cycle start-of-frame pulse, already synchronous to clk25
cam_eof  in  1  1-cycle end-of-frame pulse
cam_we  in  1  capture pixel write strobe
cam_addr  in  ADDR_W  capture pixel address
cam_data  in  DATA_W  capture pixel data
vga_vsync  in  1  VGA vsync output
vga_addr  in  ADDR_W  VGA read address
fb_we  out  1  frame buffer write enable (registered)
fb_waddr  out  ADDR_W+1  {wr_bank, cam_addr} (registered)
fb_wdata  out  DATA_W  registered cam_data
fb_raddr  out  ADDR_W+1  {rd_bank, vga_addr}, combinational
front_bank  out  1  current rd_bank
swap_pulse  out  1  1-cycle pulse in the cycle after a swap
drop_count  out  CNT_W  saturating count of dropped camera frames
err_count  out  CNT_W  saturating count of short or aborted frames

Behaviour:
Reset values:
- State WAIT_SOF; wr_bank=1, rd_bank=0.
- fb_we=0, fb_waddr=0, fb_wdata=0, swap_pulse=0.
- pix_cnt=0, drop_count=0, err_count=0.
- vsync_q = !VSYNC_ACTIVE.
- Reset taken mid-frame discards the partial frame. No swap occurs that cycle.

vsync detection:
- vs_edge = (vsync_q != VSYNC_ACTIVE) && (vga_vsync == VSYNC_ACTIVE).
- vsync_q <= vga_vsync every cycle.

State WAIT_SOF:
- Writes are blocked.
- cam_sof -> FILL, pix_cnt <= 0.

State FILL:
- Write accepted when cam_we && pix_cnt < FRAME_PIXELS. Next cycle: fb_we=1, fb_waddr={wr_bank, cam_addr}, fb_wdata=cam_data (latency 1). pix_cnt increments on each accepted write.
- cam_we once pix_cnt == FRAME_PIXELS: write suppressed, not an error.
- cam_eof with pix_cnt == FRAME_PIXELS -> READY.
- cam_eof with pix_cnt < FRAME_PIXELS -> WAIT_SOF, err_count+1.
- cam_sof with no preceding eof (aborted frame): err_count+1, pix_cnt <= 0, stay in FILL.
- cam_eof and cam_sof in the same cycle: eof is evaluated first, then sof is applied. The next state is FILL (restart) if the frame was complete, and err_count+1 otherwise.

State READY:
- Writes are blocked (back bank protected).
- On vs_edge: rd_bank <= wr_bank, wr_bank <= ~wr_bank, swap_pulse=1 next cycle, -> WAIT_SOF.
- cam_sof without vs_edge: drop_count+1, stay in READY.
- cam_sof in the same cycle as vs_edge: swap, then -> FILL with pix_cnt <= 0. No drop is counted.

Invariants and arithmetic:
- fb_we is 0 whenever the state is not FILL.
- rd_bank != wr_bank at all times after reset.
- rd_bank changes only in the cycle after vs_edge, i.e. inside vertical blanking.
- Statistics counters saturate at 2^CNT_W-1 and never wrap.
- pix_cnt is ADDR_W bits wide.

Optional Feature:
FRAME_SWAP_STATS_EN
- Defined: drop_count and err_count are implemented as above.
- Undefined: both outputs are tied to 0 and the counter logic is removed. The swap and gating behaviour is identical either way.

Decomposition:
- Package frame_swap_pkg holds: the state enum (WAIT_SOF, FILL, READY), FRAME_PIXELS, and the VGA constants H_RES=640 and V_RES=480.
- One natural sub-module, sat_counter: CNT_W saturating incrementer, instanced twice, only under FRAME_SWAP_STATS_EN.

Test Plan:
1. Reset, then 307200 writes between sof and eof, then a vsync falling edge -> swap_pulse=1 once; front_bank goes 0->1; fb_raddr MSB=1.
2. Frame with 1000 writes then eof -> back to WAIT_SOF, err_count=1, no swap on the next vsync, front_bank stays 0.
3. Complete frame, then 3 cam_sof pulses before vsync -> drop_count=3 and fb_we stays 0; the swap still occurs on the vsync edge.
4. READY with cam_sof coincident with the vsync edge -> swap, state FILL; the next cam_we appears as fb_we=1 with fb_waddr[19] equal to the new wr_bank; drop_count unchanged.
5. Write 307205 pixels -> exactly 307200 fb_we cycles; eof moves to READY with no error.
6. resetn low mid-FILL for 1 cycle -> all outputs at reset values, wr_bank=1, rd_bank=0. With FRAME_SWAP_STATS_EN undefined, counters read 0 in scenarios 2 and 3.

Source files
------------

// File: rtl/frame_swap_pkg.sv
// frame_swap_pkg: shared state encoding and video constants
// for the camera/VGA double-buffer scheduler.
package frame_swap_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF,
    FILL,
    READY
  } state_e;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int FRAME_PIXELS = H_RES * V_RES;

endpackage

// File: rtl/frame_swap_ctrl_sat_counter.sv
// sat_counter: increment-by-one statistics counter that sticks
// at all-ones instead of wrapping.
module sat_counter
  import frame_swap_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/frame_swap_ctrl.sv
// frame_swap_ctrl: tear-free double-buffer bank scheduler between
// capture and VGA scan-out. Stats counters need FRAME_SWAP_STATS_EN.
module frame_swap_ctrl #(
  parameter int   ADDR_W       = 19,
  parameter int   DATA_W       = 12,
  parameter int   FRAME_PIXELS = frame_swap_pkg::FRAME_PIXELS,
  parameter int   CNT_W        = 8,
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input  logic              clk25,
  input  logic              resetn,
  input  logic              cam_sof,
  input  logic              cam_eof,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              vga_vsync,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              fb_we,
  output logic [ADDR_W:0]   fb_waddr,
  output logic [DATA_W-1:0] fb_wdata,
  output logic [ADDR_W:0]   fb_raddr,
  output logic              front_bank,
  output logic              swap_pulse,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  err_count
);
  import frame_swap_pkg::*;

  localparam logic [ADDR_W-1:0] FULL = ADDR_W'(FRAME_PIXELS);

  state_e            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W:0]   fb_waddr_q, fb_waddr_d;
  logic [DATA_W-1:0] fb_wdata_q, fb_wdata_d;
  logic              swap_q, swap_d;
  logic              vsync_q;
  logic              vs_edge;
  logic              drop_inc;
  logic              err_inc;

  assign vs_edge = (vsync_q != VSYNC_ACTIVE) &&
                   (vga_vsync == VSYNC_ACTIVE);

  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    pix_cnt_d  = pix_cnt_q;
    fb_we_d    = 1'b0;
    fb_waddr_d = fb_waddr_q;
    fb_wdata_d = fb_wdata_q;
    swap_d     = 1'b0;
    drop_inc   = 1'b0;
    err_inc    = 1'b0;
    unique case (state_q)
      WAIT_SOF: begin
        if (cam_sof) begin
          state_d   = FILL;
          pix_cnt_d = '0;
        end
      end
      FILL: begin
        if (cam_we && (pix_cnt_q < FULL)) begin
          fb_we_d    = 1'b1;
          fb_waddr_d = {wr_bank_q, cam_addr};
          fb_wdata_d = cam_data;
          pix_cnt_d  = pix_cnt_q + ADDR_W'(1);
        end
        // eof is judged first; a coincident sof then restarts the fill
        if (cam_eof) begin
          if (pix_cnt_q == FULL) begin
            state_d = READY;
          end else begin
            state_d = WAIT_SOF;
            err_inc = 1'b1;
          end
        end else if (cam_sof) begin
          err_inc = 1'b1;
        end
        if (cam_sof) begin
          state_d   = FILL;
          pix_cnt_d = '0;
        end
      end
      READY: begin
        if (vs_edge) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          swap_d    = 1'b1;
          state_d   = cam_sof ? FILL : WAIT_SOF;
          if (cam_sof) pix_cnt_d = '0;
        end else if (cam_sof) begin
          drop_inc = 1'b1;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (!resetn) begin
      state_q    <= WAIT_SOF;
      wr_bank_q  <= 1'b1;
      rd_bank_q  <= 1'b0;
      pix_cnt_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_waddr_q <= '0;
      fb_wdata_q <= '0;
      swap_q     <= 1'b0;
      vsync_q    <= ~VSYNC_ACTIVE;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      pix_cnt_q  <= pix_cnt_d;
      fb_we_q    <= fb_we_d;
      fb_waddr_q <= fb_waddr_d;
      fb_wdata_q <= fb_wdata_d;
      swap_q     <= swap_d;
      vsync_q    <= vga_vsync;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_waddr   = fb_waddr_q;
  assign fb_wdata   = fb_wdata_q;
  assign fb_raddr   = {rd_bank_q, vga_addr};
  assign front_bank = rd_bank_q;
  assign swap_pulse = swap_q;

`ifdef FRAME_SWAP_STATS_EN
  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk25),
    .rst_n (resetn),
    .inc   (drop_inc),
    .count (drop_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk25),
    .rst_n (resetn),
    .inc   (err_inc),
    .count (err_count)
  );
`else
  logic unused_stats;
  assign unused_stats = drop_inc ^ err_inc;
  assign drop_count   = '0;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// tb_frame_swap_ctrl: directed bench for the double-buffer scheduler,
// run with a 64-pixel frame to keep the cycle count small.
module tb_frame_swap_ctrl;

  localparam int AW = 19;
  localparam int DW = 12;
  localparam int CW = 8;
  localparam int FP = 64;
`ifdef FRAME_SWAP_STATS_EN
  localparam int ST = 1;
`else
  localparam int ST = 0;
`endif

  logic          clk25     = 1'b0;
  logic          resetn    = 1'b0;
  logic          cam_sof   = 1'b0;
  logic          cam_eof   = 1'b0;
  logic          cam_we    = 1'b0;
  logic [AW-1:0] cam_addr  = '0;
  logic [DW-1:0] cam_data  = '0;
  logic          vga_vsync = 1'b1;
  logic [AW-1:0] vga_addr  = '0;
  logic          fb_we;
  logic [AW:0]   fb_waddr;
  logic [DW-1:0] fb_wdata;
  logic [AW:0]   fb_raddr;
  logic          front_bank;
  logic          swap_pulse;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] err_count;

  int n_run  = 0;
  int n_fail = 0;
  int we_seen    = 0;
  int swaps_seen = 0;

  frame_swap_ctrl #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .FRAME_PIXELS (FP),
    .CNT_W        (CW),
    .VSYNC_ACTIVE (1'b0)
  ) dut (
    .clk25      (clk25),
    .resetn     (resetn),
    .cam_sof    (cam_sof),
    .cam_eof    (cam_eof),
    .cam_we     (cam_we),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .vga_vsync  (vga_vsync),
    .vga_addr   (vga_addr),
    .fb_we      (fb_we),
    .fb_waddr   (fb_waddr),
    .fb_wdata   (fb_wdata),
    .fb_raddr   (fb_raddr),
    .front_bank (front_bank),
    .swap_pulse (swap_pulse),
    .drop_count (drop_count),
    .err_count  (err_count)
  );

  always #5 clk25 = ~clk25;

  always @(negedge clk25) begin
    if (fb_we) we_seen++;
    if (swap_pulse) swaps_seen++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic vsync_pulse();
    vga_vsync = 1'b0;
    tick();
    vga_vsync = 1'b1;
    tick();
  endtask

  task automatic write_frame(input int n, input logic bank,
                             output int nwe);
    int w0;
    cam_we  = 1'b0;
    cam_sof = 1'b1;
    tick();
    cam_sof = 1'b0;
    w0 = we_seen;
    for (int i = 0; i < n; i++) begin
      cam_we   = 1'b1;
      cam_addr = AW'(i + 100);
      cam_data = DW'(i * 3 + 1);
      tick();
      if (i == 2) begin
        chk("wr_addr", 32'(fb_waddr), 32'({bank, AW'(i + 100)}));
        chk("wr_data", 32'(fb_wdata), 32'(DW'(i * 3 + 1)));
      end
    end
    cam_we  = 1'b0;
    cam_eof = 1'b1;
    tick();
    cam_eof = 1'b0;
    nwe = we_seen - w0;
  endtask

  initial begin
    int nwe;
    int s0;
    int w0;
    vga_addr = AW'(5);
    tick();
    tick();
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_waddr", 32'(fb_waddr), 0);
    chk("rst_wdata", 32'(fb_wdata), 0);
    chk("rst_swap", 32'(swap_pulse), 0);
    chk("rst_front", 32'(front_bank), 0);
    chk("rst_raddr", 32'(fb_raddr), 5);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_err", 32'(err_count), 0);
    resetn = 1'b1;

    // full frame then vsync: one swap, front 0 -> 1
    write_frame(FP, 1'b1, nwe);
    chk("t1_we_cnt", nwe, FP);
    s0 = swaps_seen;
    vga_vsync = 1'b0;
    tick();
    chk("t1_pulse", 32'(swap_pulse), 1);
    chk("t1_front", 32'(front_bank), 1);
    chk("t1_raddr", 32'(fb_raddr), 32'({1'b1, AW'(5)}));
    vga_vsync = 1'b1;
    tick();
    chk("t1_pulse_off", 32'(swap_pulse), 0);
    chk("t1_swaps", swaps_seen - s0, 1);

    // short frame: error, no swap
    write_frame(20, 1'b0, nwe);
    chk("t2_we_cnt", nwe, 20);
    chk("t2_err", 32'(err_count), ST);
    s0 = swaps_seen;
    vsync_pulse();
    chk("t2_swaps", swaps_seen - s0, 0);
    chk("t2_front", 32'(front_bank), 1);

    // complete frame, 3 sofs in READY are drops
    write_frame(FP, 1'b0, nwe);
    w0 = we_seen;
    repeat (3) begin
      cam_we  = 1'b1;
      cam_sof = 1'b1;
      tick();
      cam_sof = 1'b0;
      tick();
    end
    chk("t3_fb_we", 32'(fb_we), 0);
    cam_we = 1'b0;
    tick();
    chk("t3_blocked", we_seen - w0, 0);
    chk("t3_drop", 32'(drop_count), 3 * ST);
    vsync_pulse();
    chk("t3_front", 32'(front_bank), 0);

    // sof coincident with vsync edge: swap and straight into FILL
    write_frame(FP, 1'b1, nwe);
    cam_sof   = 1'b1;
    vga_vsync = 1'b0;
    tick();
    cam_sof   = 1'b0;
    vga_vsync = 1'b1;
    chk("t4_pulse", 32'(swap_pulse), 1);
    chk("t4_front", 32'(front_bank), 1);
    cam_we   = 1'b1;
    cam_addr = AW'(7);
    cam_data = DW'(12'habc);
    tick();
    cam_we = 1'b0;
    chk("t4_fb_we", 32'(fb_we), 1);
    chk("t4_waddr", 32'(fb_waddr), 32'({1'b0, AW'(7)}));
    chk("t4_wdata", 32'(fb_wdata), 32'h abc);
    chk("t4_drop", 32'(drop_count), 3 * ST);

    // overrun: sof aborts the FILL, extra writes suppressed
    write_frame(FP + 5, 1'b0, nwe);
    chk("t5_we_cnt", nwe, FP);
    chk("t5_err", 32'(err_count), 2 * ST);
    vsync_pulse();
    chk("t5_front", 32'(front_bank), 0);

    // reset mid-FILL with rd_bank=1
    write_frame(FP, 1'b1, nwe);
    vsync_pulse();
    chk("t6_front_pre", 32'(front_bank), 1);
    cam_sof = 1'b1;
    tick();
    cam_sof  = 1'b0;
    cam_we   = 1'b1;
    cam_addr = AW'(9);
    tick();
    chk("t6_bank_pre", 32'(fb_waddr), 32'({1'b0, AW'(9)}));
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("t6_fb_we", 32'(fb_we), 0);
    chk("t6_waddr", 32'(fb_waddr), 0);
    chk("t6_wdata", 32'(fb_wdata), 0);
    chk("t6_front", 32'(front_bank), 0);
    chk("t6_swap", 32'(swap_pulse), 0);
    chk("t6_drop", 32'(drop_count), 0);
    chk("t6_err", 32'(err_count), 0);
    tick();
    chk("t6_wait_sof", 32'(fb_we), 0);
    cam_we = 1'b0;
    write_frame(FP, 1'b1, nwe);
    chk("t6_we_cnt", nwe, FP);

    // drop counter saturates
    repeat (300) begin
      cam_sof = 1'b1;
      tick();
      cam_sof = 1'b0;
      tick();
    end
    chk("sat_drop", 32'(drop_count), 255 * ST);
    chk("sat_front", 32'(front_bank), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
